// File: rtl/regfile_pkg.sv
// Shared defaults, typedefs and the clear-sequencer state enum for regfile_sb.
package regfile_pkg;

    localparam int NREG_DEF = 64;
    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Bundle of read, issue and writeback signals between the core and regfile_sb.
// master: decode/issue + writeback side; slave: the register file.
interface regfile_sb_if #(
    parameter int NREG = 64,
    parameter int XLEN = 32,
    parameter int NRD  = 4,
    parameter int NWR  = 2,
    parameter int NISS = 2,
    parameter int AW   = $clog2(NREG)
);
    logic                      ready;
    logic [NRD-1:0][AW-1:0]    ar;
    logic [NRD-1:0][XLEN-1:0]  rd;
    logic [NRD-1:0]            rbusy;
    logic [NISS-1:0]           iss_v;
    logic [NISS-1:0][AW-1:0]   iss_dst;
    logic [NWR-1:0]            we;
    logic [NWR-1:0][AW-1:0]    aw;
    logic [NWR-1:0][XLEN-1:0]  wd;
    logic [NWR-1:0]            wclr;

    modport master (
        input  ready, rd, rbusy,
        output ar, iss_v, iss_dst, we, aw, wd, wclr
    );

    modport slave (
        output ready, rd, rbusy,
        input  ar, iss_v, iss_dst, we, aw, wd, wclr
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback (set wins),
// cleared one entry per cycle by the parent's init sequencer.
module regfile_scoreboard #(
    parameter int NREG = 64,
    parameter int NRD  = 4,
    parameter int NWR  = 2,
    parameter int NISS = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic [NISS-1:0]         iss_v,
    input  logic [NISS-1:0][AW-1:0] iss_dst,
    input  logic [NWR-1:0]          wclr_v,
    input  logic [NWR-1:0][AW-1:0]  wclr_idx,
    input  logic                    clr_v,
    input  logic [AW-1:0]           clr_idx,
    input  logic [NRD-1:0][AW-1:0]  ar,
    output logic [NRD-1:0]          busy_rd
);

    logic [NREG-1:0] busy_q, busy_d;

    // Next busy vector: a new producer supersedes a retiring one.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            logic set_r, clr_r;
            set_r = 1'b0;
            clr_r = 1'b0;
            for (int j = 0; j < NISS; j++)
                if (iss_v[j] && iss_dst[j] == AW'(r)) set_r = 1'b1;
            for (int k = 0; k < NWR; k++)
                if (wclr_v[k] && wclr_idx[k] == AW'(r)) clr_r = 1'b1;
            if (set_r)      busy_d[r] = 1'b1;
            else if (clr_r) busy_d[r] = 1'b0;
        end
        if (clr_v) busy_d[clr_idx] = 1'b0;
        // Register 0 has no producer, so it is never busy.
        busy_d[0] = 1'b0;
    end

    // Busy state register; initialised by the parent's clear sequence.
    always_ff @(posedge clk) begin
        busy_q <= busy_d;
    end

    // Registered busy lookup, no same-cycle bypass.
    always_comb begin
        busy_rd = '0;
        for (int i = 0; i < NRD; i++) busy_rd[i] = busy_q[ar[i]];
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with scoreboard and hardware clear sequencer.
// Optional write-to-read bypass enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int XLEN = XLEN_DEF,
    parameter int NRD  = 4,
    parameter int NWR  = 2,
    parameter int NISS = 2,
    parameter int AW   = $clog2(NREG)
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);

    state_t            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [XLEN-1:0]   rf_q [NREG];
    logic [XLEN-1:0]   rf_d [NREG];

    logic              run_en, init_en;
    logic [NWR-1:0]    we_g, wclr_g;
    logic [NISS-1:0]   iss_g;
    logic [NRD-1:0]    busy_rd;
    logic [NRD-1:0][XLEN-1:0] rd_c;
    logic [NRD-1:0]    rbusy_c;

    // Updates only take effect in RUN and never in a reset cycle.
    assign run_en  = (state_q == RUN)  && !rst;
    assign init_en = (state_q == INIT) && !rst;
    assign we_g    = bus.we & {NWR{run_en}};
    assign wclr_g  = we_g & bus.wclr;
    assign iss_g   = bus.iss_v & {NISS{run_en}};

    // Clear sequencer: walk ptr from 1 to NREG-1, then enter RUN.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == INIT) begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == AW'(NREG - 1)) state_d = RUN;
        end
    end

    // Sequencer state; reset restarts the walk at register 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            ptr_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Array update: init clear, or writes in ascending port order so the highest port wins.
    always_comb begin
        rf_d = rf_q;
        if (init_en) rf_d[ptr_q] = '0;
        for (int k = 0; k < NWR; k++)
            if (we_g[k] && bus.aw[k] != '0) rf_d[bus.aw[k]] = bus.wd[k];
    end

    // Register array storage.
    always_ff @(posedge clk) begin
        rf_q <= rf_d;
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR),
        .NISS (NISS),
        .AW   (AW)
    ) u_sb (
        .clk      (clk),
        .iss_v    (iss_g),
        .iss_dst  (bus.iss_dst),
        .wclr_v   (wclr_g),
        .wclr_idx (bus.aw),
        .clr_v    (init_en),
        .clr_idx  (ptr_q),
        .ar       (bus.ar),
        .busy_rd  (busy_rd)
    );

    // Read ports: zero in INIT or for r0, optional bypass from write ports.
    always_comb begin
        rd_c    = '0;
        rbusy_c = '0;
        for (int i = 0; i < NRD; i++) begin
            if (state_q == INIT) begin
                rbusy_c[i] = 1'b1;
            end else if (bus.ar[i] != '0) begin
                rd_c[i]    = rf_q[bus.ar[i]];
                rbusy_c[i] = busy_rd[i];
`ifdef REGFILE_SB_BYPASS_EN
                for (int k = 0; k < NWR; k++)
                    if (we_g[k] && bus.aw[k] == bus.ar[i]) rd_c[i] = bus.wd[k];
`endif
            end
        end
    end

    assign bus.rd    = rd_c;
    assign bus.rbusy = rbusy_c;
    assign bus.ready = (state_q == RUN);

endmodule
